pipeline_ctrl: RTL and testbench

- Central sequencer for the 5-stage ARM pipeline. Replaces the hard-wired freeze/flush/hazard constants.
- Detects RAW data hazards between ID and EXE/MEM, with or without forwarding.
- Flushes IF/ID and ID/EXE on a taken branch.
- Owns the request/ready handshake with the data SRAM and freezes the whole pipeline while an access is outstanding, with a timeout fault.
- Provides saturating stall/flush performance counters.

---
 rtl/pipeline_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central hazard / flush / memory-freeze sequencer for the
// 5-stage ARM pipeline. It detects RAW hazards between ID and EXE/MEM and
// owns the data-SRAM request/ready handshake, with a timeout fault.
// It also keeps saturating stall and flush performance counters.
module pipeline_ctrl #(
  parameter int FWD_EN      = 1,   // 1: forwarding present, only load-use stalls
  parameter int MEM_TIMEOUT = 64,  // WAIT cycles without sram_ready before FAULT (2..255)
  parameter int CNT_W       = 16   // performance counter width
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_valid,
  input  logic             exe_wb_en,
  input  logic [3:0]       exe_dest,
  input  logic             exe_mem_r_en,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_req,
  input  logic             branch_taken,
  input  logic             sram_ready,
  output logic             sram_req,
  output logic             freeze,
  output logic             hazard,
  output logic             flush,
  output logic             stall_all,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Last counter value tolerated in WAIT before giving up on the SRAM.
  localparam logic [7:0]       TMO_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [7:0]       tmo_reg, tmo_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  // ---------------------------------------------------------------------------
  // RAW hazard detection, one comparator set per ID source operand.
  // Both the load-use and the full-RAW match are built; FWD_EN picks one.
  // ---------------------------------------------------------------------------
  logic [3:0] src_addr [2];
  logic [1:0] src_used;
  logic [1:0] src_hit;
  logic       raw_hz;

  assign src_addr[0] = id_src1;
  assign src_addr[1] = id_src2;
  assign src_used    = {id_two_src, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic load_hit;
      logic any_hit;
      // With forwarding only a load still in EXE cannot be bypassed in time.
      assign load_hit = exe_wb_en & exe_mem_r_en & (exe_dest == src_addr[gi]);
      assign any_hit  = (exe_wb_en & (exe_dest == src_addr[gi])) |
                        (mem_wb_en & (mem_dest == src_addr[gi]));
      assign src_hit[gi] = src_used[gi] & ((FWD_EN != 0) ? load_hit : any_hit);
    end
  endgenerate

  assign raw_hz = id_valid & (|src_hit);

  // State and timeout counter registers; reset drops any outstanding access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_RUN;
      tmo_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
    end
  end

  // Next-state logic for the SRAM handshake; ready outside WAIT is ignored.
  always_comb begin
    state_next = state_reg;
    tmo_next   = tmo_reg;
    unique case (state_reg)
      ST_RUN: begin
        tmo_next = 8'd0;
        if (mem_req) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (sram_ready)               state_next = ST_DONE;
        else if (tmo_reg == TMO_LAST) state_next = ST_FAULT;
        else                          tmo_next   = tmo_reg + 8'd1;
      end
      ST_DONE: begin
        // One free cycle so MEM advances and the access is not re-issued.
        state_next = ST_RUN;
        tmo_next   = 8'd0;
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_RUN;
        tmo_next   = 8'd0;
      end
    endcase
  end

  // Pipeline control outputs; stall starts combinationally with mem_req in RUN.
  always_comb begin
    sram_req  = 1'b0;
    stall_all = 1'b0;
    mem_error = 1'b0;
    unique case (state_reg)
      ST_RUN: begin
        sram_req  = mem_req;
        stall_all = mem_req;
      end
      ST_WAIT: begin
        sram_req  = 1'b1;
        stall_all = 1'b1;
      end
      ST_DONE: begin
        sram_req  = 1'b0;
        stall_all = 1'b0;
      end
      ST_FAULT: begin
        stall_all = 1'b1;
        mem_error = 1'b1;
      end
      default: begin
        sram_req  = 1'b0;
      end
    endcase
    // A taken branch discards the ID instruction, so it never hazards.
    hazard = raw_hz & ~stall_all & ~branch_taken;
    flush  = branch_taken & ~stall_all;
    freeze = stall_all | hazard;
  end

  // Saturating performance counters for stall cycles and flush events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if ((stall_all | hazard) && (stall_cnt_reg != CNT_MAX))
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      if (flush && (flush_cnt_reg != CNT_MAX))
        flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: two pipeline_ctrl instances share one stimulus stream.
// Instance a: forwarding, short timeout, 4-bit counters.
// Instance b: no forwarding, default timeout, 16-bit counters.
// A reference model predicts every output; a negedge monitor scores it.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
  logic       id_two_src = 1'b0, id_valid = 1'b0, exe_wb_en = 1'b0;
  logic       exe_mem_r_en = 1'b0, mem_wb_en = 1'b0, mem_req = 1'b0;
  logic       branch_taken = 1'b0, sram_ready = 1'b0;

  logic        a_sram_req, a_freeze, a_hazard, a_flush, a_stall_all, a_mem_error;
  logic [3:0]  a_stall_cnt, a_flush_cnt;
  logic        b_sram_req, b_freeze, b_hazard, b_flush, b_stall_all, b_mem_error;
  logic [15:0] b_stall_cnt, b_flush_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_req(mem_req),
    .branch_taken(branch_taken), .sram_ready(sram_ready),
    .sram_req(a_sram_req), .freeze(a_freeze), .hazard(a_hazard), .flush(a_flush),
    .stall_all(a_stall_all), .mem_error(a_mem_error),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipeline_ctrl #(.FWD_EN(0), .MEM_TIMEOUT(64), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_req(mem_req),
    .branch_taken(branch_taken), .sram_ready(sram_ready),
    .sram_req(b_sram_req), .freeze(b_freeze), .hazard(b_hazard), .flush(b_flush),
    .stall_all(b_stall_all), .mem_error(b_mem_error),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  typedef struct {
    logic [3:0] src1, src2;
    logic       two, vld, ewb;
    logic [3:0] edst;
    logic       erd, mwb;
    logic [3:0] mdst;
    logic       mreq, br, rdy;
  } stim_t;

  // flags = {sram_req, freeze, hazard, flush, stall_all, mem_error}
  typedef struct {
    int         inst;
    int         cyc;
    logic [5:0] flags;
    int         scnt;
    int         fcnt;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;

  // Per-instance parameters and abstract memory-access bookkeeping.
  int fwd_p [2] = '{1, 0};
  int to_p  [2] = '{4, 64};
  int max_p [2] = '{15, 65535};
  bit m_busy [2];   // access outstanding, waiting for sram_ready
  bit m_rel  [2];   // access just completed, one free cycle pending
  bit m_dead [2];   // timed out, stuck until reset
  int m_wait [2];   // WAIT cycles already spent without ready
  int m_scnt [2];
  int m_fcnt [2];

  function automatic bit producer_blocks(int i, stim_t s, logic [3:0] r);
    if (fwd_p[i] != 0) return s.ewb && s.erd && (s.edst == r);
    return (s.ewb && (s.edst == r)) || (s.mwb && (s.mdst == r));
  endfunction

  function automatic void model_reset(int i);
    m_busy[i] = 0; m_rel[i] = 0; m_dead[i] = 0;
    m_wait[i] = 0; m_scnt[i] = 0; m_fcnt[i] = 0;
  endfunction

  // Predict this cycle's outputs, then advance the model across the clock edge.
  function automatic void model_cycle(int i, stim_t s, output exp_t e);
    bit idle, raw, stall, sreq, hz, fl;
    idle  = !m_busy[i] && !m_rel[i] && !m_dead[i];
    raw   = s.vld && (producer_blocks(i, s, s.src1) ||
                      (s.two && producer_blocks(i, s, s.src2)));
    stall = m_dead[i] || m_busy[i] || (idle && s.mreq);
    sreq  = m_busy[i] || (idle && s.mreq);
    hz    = raw && !stall && !s.br;
    fl    = s.br && !stall;
    e = '{default: 0};
    e.inst  = i;
    e.cyc   = cyc;
    e.flags = {sreq, stall || hz, hz, fl, stall, m_dead[i]};
    e.scnt  = m_scnt[i];
    e.fcnt  = m_fcnt[i];
    if ((stall || hz) && m_scnt[i] < max_p[i]) m_scnt[i]++;
    if (fl && m_fcnt[i] < max_p[i]) m_fcnt[i]++;
    if (m_dead[i]) begin
    end else if (m_busy[i]) begin
      if (s.rdy) begin
        m_busy[i] = 0; m_rel[i] = 1;
      end else if (m_wait[i] == to_p[i] - 1) begin
        m_busy[i] = 0; m_dead[i] = 1;
      end else begin
        m_wait[i]++;
      end
    end else if (m_rel[i]) begin
      m_rel[i] = 0;
    end else if (s.mreq) begin
      m_busy[i] = 1; m_wait[i] = 0;
    end
  endfunction

  // Drive one cycle of stimulus shortly after the edge and queue predictions.
  task automatic apply(stim_t s, bit rst_v);
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    rst = rst_v;
    if (!rst_v) s = '{default: 0};
    id_src1 = s.src1; id_src2 = s.src2; id_two_src = s.two; id_valid = s.vld;
    exe_wb_en = s.ewb; exe_dest = s.edst; exe_mem_r_en = s.erd;
    mem_wb_en = s.mwb; mem_dest = s.mdst; mem_req = s.mreq;
    branch_taken = s.br; sram_ready = s.rdy;
    for (int i = 0; i < 2; i++) begin
      if (!rst_v) begin
        model_reset(i);
        e = '{default: 0};
        e.inst = i;
        e.cyc  = cyc;
      end else begin
        model_cycle(i, s, e);
      end
      sbq.push_back(e);
    end
  endtask

  task automatic check_val(string name, int got, int want);
    n_checks++;
    if (got != want) begin
      n_fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end else begin
      $display("check %s: %0d as expected", name, got);
    end
  endtask

  // Monitor: score every queued prediction against the DUT away from the edge.
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t       e;
      logic [5:0] act;
      int         as, af;
      e = sbq.pop_front();
      if (e.inst == 0) begin
        act = {a_sram_req, a_freeze, a_hazard, a_flush, a_stall_all, a_mem_error};
        as  = int'(a_stall_cnt);
        af  = int'(a_flush_cnt);
      end else begin
        act = {b_sram_req, b_freeze, b_hazard, b_flush, b_stall_all, b_mem_error};
        as  = int'(b_stall_cnt);
        af  = int'(b_flush_cnt);
      end
      n_checks++;
      if ((act !== e.flags) || (as != e.scnt) || (af != e.fcnt)) begin
        n_fails++;
        $display("FAIL dut%0d cycle %0d: flags(req,frz,hz,fl,stall,err) got %b want %b, stall_cnt got %0d want %0d, flush_cnt got %0d want %0d",
                 e.inst, e.cyc, act, e.flags, as, e.scnt, af, e.fcnt);
      end else begin
        $display("cycle %0d dut%0d: flags=%b stall_cnt=%0d flush_cnt=%0d", e.cyc, e.inst, act, as, af);
      end
    end
  end

  initial begin
    stim_t s;
    stim_t z;
    z = '{default: 0};

    // Reset state
    repeat (3) apply(z, 0);

    // Load-use on r1: hazard in both instances, only b once it is not a load
    s = z; s.vld = 1; s.src1 = 4'd1; s.ewb = 1; s.erd = 1; s.edst = 4'd1;
    apply(s, 1);
    @(negedge clk);
    check_val("loaduse_hazard", int'(a_hazard), 1);
    check_val("loaduse_freeze", int'(a_freeze), 1);
    s.erd = 0;
    apply(s, 1);
    @(negedge clk);
    check_val("nonload_fwd_hazard", int'(a_hazard), 0);

    // No forwarding: MEM destination against second source
    s = z; s.vld = 1; s.src1 = 4'd5; s.two = 1; s.src2 = 4'd3; s.mwb = 1; s.mdst = 4'd3;
    apply(s, 1);
    @(negedge clk);
    check_val("nofwd_mem_src2_hazard", int'(b_hazard), 1);
    s.two = 0;
    apply(s, 1);
    s.two = 1; s.vld = 0;
    apply(s, 1);
    @(negedge clk);
    check_val("nofwd_bubble_hazard", int'(b_hazard), 0);

    // Memory access with ready on the third WAIT cycle
    repeat (2) apply(z, 0);
    s = z; s.mreq = 1;
    repeat (3) apply(s, 1);
    s.rdy = 1;
    apply(s, 1);
    apply(z, 1);
    @(negedge clk);
    check_val("done_stall_all", int'(a_stall_all), 0);
    check_val("done_sram_req", int'(a_sram_req), 0);
    check_val("access_stall_cnt", int'(a_stall_cnt), 4);

    // Branch held during a memory stall flushes only on the DONE cycle
    repeat (2) apply(z, 0);
    s = z; s.mreq = 1; s.br = 1;
    repeat (2) apply(s, 1);
    s.rdy = 1;
    apply(s, 1);
    s = z; s.br = 1;
    apply(s, 1);
    @(negedge clk);
    check_val("done_branch_flush", int'(a_flush), 1);
    apply(z, 1);
    @(negedge clk);
    check_val("flush_cnt_after_done", int'(a_flush_cnt), 1);

    // Branch wins over a simultaneous load-use hazard
    s = z; s.br = 1; s.vld = 1; s.src1 = 4'd2; s.ewb = 1; s.erd = 1; s.edst = 4'd2;
    apply(s, 1);
    @(negedge clk);
    check_val("branch_hz_flush", int'(a_flush), 1);
    check_val("branch_hz_hazard", int'(a_hazard), 0);
    check_val("branch_hz_freeze", int'(a_freeze), 0);

    // Timeout: instance a faults after four WAIT cycles, late ready ignored
    repeat (2) apply(z, 0);
    s = z; s.mreq = 1;
    apply(s, 1);
    repeat (4) apply(s, 1);
    apply(z, 1);
    @(negedge clk);
    check_val("timeout_mem_error", int'(a_mem_error), 1);
    check_val("timeout_stall_all", int'(a_stall_all), 1);
    s = z; s.rdy = 1;
    apply(s, 1);
    apply(z, 1);
    @(negedge clk);
    check_val("late_ready_mem_error", int'(a_mem_error), 1);

    // Continuous stall saturates the 4-bit counter
    repeat (20) apply(z, 1);
    @(negedge clk);
    check_val("stall_cnt_saturated", int'(a_stall_cnt), 15);
    apply(z, 0);
    @(negedge clk);
    check_val("reset_clears_fault", int'(a_mem_error), 0);

    // Reset in the middle of WAIT drops sram_req without waiting for a clock
    apply(z, 1);
    s = z; s.mreq = 1;
    repeat (2) apply(s, 1);
    apply(z, 0);
    @(negedge clk);
    check_val("async_reset_sram_req", int'(a_sram_req), 0);
    apply(z, 1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      bit rv;
      s.src1 = 4'($urandom_range(0, 3));
      s.src2 = 4'($urandom_range(0, 3));
      s.edst = 4'($urandom_range(0, 3));
      s.mdst = 4'($urandom_range(0, 3));
      s.two  = ($urandom_range(0, 99) < 50);
      s.vld  = ($urandom_range(0, 99) < 80);
      s.ewb  = ($urandom_range(0, 99) < 60);
      s.erd  = ($urandom_range(0, 99) < 40);
      s.mwb  = ($urandom_range(0, 99) < 60);
      s.mreq = ($urandom_range(0, 99) < 30);
      s.br   = ($urandom_range(0, 99) < 20);
      s.rdy  = ($urandom_range(0, 99) < 30);
      rv     = ($urandom_range(0, 49) != 0);
      apply(s, rv);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (sbq.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
